// File: rtl/mc_sched_pkg.sv
// Shared types and index-width helper for the multi-cycle unit pool scheduler.
package mc_sched_pkg;

    typedef enum logic [1:0] {
        FREE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } unit_state_e;

    typedef enum logic {
        IDLE    = 1'b0,
        PENDING = 1'b1
    } port_state_e;

    localparam int MIN_POOL_SIZE = 2;

    // Index width for a pool of n entries; pools are at least two wide.
    function automatic int idx_width(input int n);
        return (n < MIN_POOL_SIZE) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/pool_rr_allocator.sv
// Combinational multi-grant round-robin allocator: requesting ports, scanned from
// rr_ptr, each take the lowest-index still-available free unit.
module pool_rr_allocator
    import mc_sched_pkg::*;
#(
    parameter int NUM_PORTS = 4,
    parameter int NUM_UNITS = 2,
    localparam int PW = idx_width(NUM_PORTS),
    localparam int UW = idx_width(NUM_UNITS)
) (
    input  logic [NUM_PORTS-1:0] req,
    input  logic [NUM_UNITS-1:0] free,
    input  logic [PW-1:0]        rr_ptr,
    output logic [NUM_PORTS-1:0] grant,
    output logic [UW-1:0]        unit_idx [NUM_PORTS],
    output logic [PW-1:0]        next_ptr
);

    logic [NUM_UNITS-1:0] avail;
    logic                 found;
    int                   p;

    // NOTE: every comb output gets a default before the loops, so no latch is inferred.
    always_comb begin
        grant    = '0;
        next_ptr = rr_ptr;
        avail    = free;
        found    = 1'b0;
        p        = 0;
        for (int i = 0; i < NUM_PORTS; i++) unit_idx[i] = '0;

        for (int k = 0; k < NUM_PORTS; k++) begin
            p     = (int'(rr_ptr) + k) % NUM_PORTS;
            found = 1'b0;
            if (req[p]) begin
                for (int u = 0; u < NUM_UNITS; u++) begin
                    if (!found && avail[u]) begin
                        found       = 1'b1;
                        avail[u]    = 1'b0;
                        grant[p]    = 1'b1;
                        unit_idx[p] = UW'(u);
                        next_ptr    = PW'((p + 1) % NUM_PORTS);
                    end
                end
            end
        end
    end

endmodule

// File: rtl/mc_unit_pool_scheduler.sv
// Binds SIC requester ports to a pool of multi-cycle units, tracks the owner while
// the unit runs and holds each captured result until the owning port accepts it.
module mc_unit_pool_scheduler
    import mc_sched_pkg::*;
#(
    parameter int NUM_UNITS = 2,
    parameter int NUM_PORTS = 4,
    parameter int ID_WIDTH  = 16,
    parameter int REQ_W     = 72,
    parameter int RESP_W    = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_PORTS-1:0] port_req_valid,
    input  logic [ID_WIDTH-1:0]  port_req_id     [NUM_PORTS],
    input  logic [REQ_W-1:0]     port_req_data   [NUM_PORTS],
    output logic [NUM_PORTS-1:0] port_req_ready,
    output logic [NUM_PORTS-1:0] port_resp_valid,
    output logic [ID_WIDTH-1:0]  port_resp_id    [NUM_PORTS],
    output logic [RESP_W-1:0]    port_resp_data  [NUM_PORTS],
    input  logic [NUM_PORTS-1:0] port_resp_ready,
    output logic [NUM_UNITS-1:0] unit_start,
    output logic [REQ_W-1:0]     unit_req_data   [NUM_UNITS],
    input  logic [NUM_UNITS-1:0] unit_done,
    input  logic [RESP_W-1:0]    unit_resp_data  [NUM_UNITS],
    output logic                 pool_busy,
    output logic                 err_spurious
);

    localparam int PW = idx_width(NUM_PORTS);
    localparam int UW = idx_width(NUM_UNITS);

    unit_state_e          unit_state     [NUM_UNITS];
    unit_state_e          unit_state_nxt [NUM_UNITS];
    logic [PW-1:0]        unit_owner     [NUM_UNITS];
    logic [ID_WIDTH-1:0]  unit_tag       [NUM_UNITS];
    logic [RESP_W-1:0]    unit_result    [NUM_UNITS];
    port_state_e          port_state     [NUM_PORTS];
    port_state_e          port_state_nxt [NUM_PORTS];

    logic [PW-1:0]        rr_ptr, rr_ptr_nxt;
    logic [NUM_PORTS-1:0] req_mask, grant;
    logic [UW-1:0]        grant_unit     [NUM_PORTS];
    logic [NUM_UNITS-1:0] free_mask, free_nxt, spurious;
    logic [PW-1:0]        start_port     [NUM_UNITS];
    logic [ID_WIDTH-1:0]  start_id       [NUM_UNITS];

    always_comb begin
        for (int p = 0; p < NUM_PORTS; p++)
            req_mask[p] = port_req_valid[p] && (port_state[p] == IDLE);
        for (int u = 0; u < NUM_UNITS; u++)
            free_mask[u] = (unit_state[u] == FREE);
    end

    pool_rr_allocator #(
        .NUM_PORTS (NUM_PORTS),
        .NUM_UNITS (NUM_UNITS)
    ) u_alloc (
        .req      (req_mask),
        .free     (free_mask),
        .rr_ptr   (rr_ptr),
        .grant    (grant),
        .unit_idx (grant_unit),
        .next_ptr (rr_ptr_nxt)
    );

    // Route grants to units; responses are driven only from registered unit state.
    always_comb begin
        port_req_ready  = grant;
        unit_start      = '0;
        port_resp_valid = '0;
        for (int u = 0; u < NUM_UNITS; u++) begin
            unit_req_data[u] = '0;
            start_port[u]    = '0;
            start_id[u]      = '0;
        end
        for (int p = 0; p < NUM_PORTS; p++) begin
            port_resp_id[p]   = '0;
            port_resp_data[p] = '0;
        end

        for (int p = 0; p < NUM_PORTS; p++) begin
            if (grant[p]) begin
                unit_start[grant_unit[p]]    = 1'b1;
                unit_req_data[grant_unit[p]] = port_req_data[p];
                start_port[grant_unit[p]]    = PW'(p);
                start_id[grant_unit[p]]      = port_req_id[p];
            end
        end
        for (int u = 0; u < NUM_UNITS; u++) begin
            if (unit_state[u] == HOLD) begin
                port_resp_valid[unit_owner[u]] = 1'b1;
                port_resp_id[unit_owner[u]]    = unit_tag[u];
                port_resp_data[unit_owner[u]]  = unit_result[u];
            end
        end
    end

    always_comb begin
        for (int u = 0; u < NUM_UNITS; u++) begin
            unit_state_nxt[u] = unit_state[u];
            spurious[u]       = 1'b0;
            case (unit_state[u])
                FREE: begin
                    if (unit_start[u]) unit_state_nxt[u] = RUN;
                    spurious[u] = unit_done[u];
                end
                RUN: begin
                    if (unit_done[u]) unit_state_nxt[u] = HOLD;
                end
                HOLD: begin
                    if (port_resp_ready[unit_owner[u]]) unit_state_nxt[u] = FREE;
                    spurious[u] = unit_done[u];
                end
                default: unit_state_nxt[u] = FREE;
            endcase
            free_nxt[u] = (unit_state_nxt[u] == FREE);
        end

        for (int p = 0; p < NUM_PORTS; p++) begin
            port_state_nxt[p] = port_state[p];
            case (port_state[p])
                IDLE:    if (grant[p]) port_state_nxt[p] = PENDING;
                PENDING: if (port_resp_valid[p] && port_resp_ready[p]) port_state_nxt[p] = IDLE;
                default: port_state_nxt[p] = IDLE;
            endcase
        end
    end

    // NOTE: sequential state is written only with non-blocking assignments.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int u = 0; u < NUM_UNITS; u++) begin
                unit_state[u]  <= FREE;
                unit_owner[u]  <= '0;
                unit_tag[u]    <= '0;
                unit_result[u] <= '0;
            end
            for (int p = 0; p < NUM_PORTS; p++) port_state[p] <= IDLE;
            rr_ptr       <= '0;
            pool_busy    <= 1'b0;
            err_spurious <= 1'b0;
        end else begin
            for (int u = 0; u < NUM_UNITS; u++) begin
                unit_state[u] <= unit_state_nxt[u];
                if (unit_start[u]) begin
                    unit_owner[u] <= start_port[u];
                    unit_tag[u]   <= start_id[u];
                end
                if (unit_state[u] == RUN && unit_done[u]) unit_result[u] <= unit_resp_data[u];
            end
            for (int p = 0; p < NUM_PORTS; p++) port_state[p] <= port_state_nxt[p];
            rr_ptr       <= rr_ptr_nxt;
            pool_busy    <= ~|free_nxt;
            err_spurious <= err_spurious | (|spurious);
        end
    end

endmodule

// File: tb/tb_mc_unit_pool_scheduler.sv
// Self-checking bench: directed scenarios plus randomized traffic, all cycles compared
// against a transaction-level reference model of ports, units and the rr pointer.
module tb_mc_unit_pool_scheduler;

    localparam int NP = 4;
    localparam int NU = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [NP-1:0] port_req_valid = '0;
    logic [15:0]   port_req_id    [NP];
    logic [71:0]   port_req_data  [NP];
    logic [NP-1:0] port_req_ready;
    logic [NP-1:0] port_resp_valid;
    logic [15:0]   port_resp_id   [NP];
    logic [63:0]   port_resp_data [NP];
    logic [NP-1:0] port_resp_ready = '1;
    logic [NU-1:0] unit_start;
    logic [71:0]   unit_req_data  [NU];
    logic [NU-1:0] unit_done = '0;
    logic [63:0]   unit_resp_data [NU];
    logic          pool_busy;
    logic          err_spurious;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: owner port per unit (-1 = free), result-held flag, pending ports.
    int          m_owner [NU];
    bit          m_held  [NU];
    logic [15:0] m_tag   [NU];
    logic [63:0] m_res   [NU];
    bit          m_pend  [NP];
    int          m_rr;
    bit          m_err;

    // Emulated multi-cycle units: cycles left until done (0 = not running).
    bit auto_units = 1'b0;
    int lat [NU];

    mc_unit_pool_scheduler dut (
        .clk             (clk),
        .rst             (rst),
        .port_req_valid  (port_req_valid),
        .port_req_id     (port_req_id),
        .port_req_data   (port_req_data),
        .port_req_ready  (port_req_ready),
        .port_resp_valid (port_resp_valid),
        .port_resp_id    (port_resp_id),
        .port_resp_data  (port_resp_data),
        .port_resp_ready (port_resp_ready),
        .unit_start      (unit_start),
        .unit_req_data   (unit_req_data),
        .unit_done       (unit_done),
        .unit_resp_data  (unit_resp_data),
        .pool_busy       (pool_busy),
        .err_spurious    (err_spurious)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic void m_reset();
        for (int u = 0; u < NU; u++) begin
            m_owner[u] = -1;
            m_held[u]  = 1'b0;
            m_tag[u]   = '0;
            m_res[u]   = '0;
            lat[u]     = 0;
        end
        for (int p = 0; p < NP; p++) m_pend[p] = 1'b0;
        m_rr  = 0;
        m_err = 1'b0;
    endfunction

    // Compare all outputs against the model for the current cycle, then advance the model.
    task automatic settle();
        int          free_q[$];
        int          n_free;
        int          last;
        int          p;
        int          u;
        logic [NP-1:0] e_ready;
        logic [NP-1:0] e_rv;
        logic [NU-1:0] e_start;
        logic [71:0] e_ureq  [NU];
        logic [15:0] e_rid   [NP];
        logic [63:0] e_rdata [NP];
        bit          hs      [NP];
        #1;
        for (int i = 0; i < NU; i++) if (m_owner[i] < 0) free_q.push_back(i);
        n_free  = free_q.size();
        e_ready = '0;
        e_start = '0;
        e_rv    = '0;
        last    = -1;
        for (int i = 0; i < NU; i++) e_ureq[i] = '0;
        for (int i = 0; i < NP; i++) begin
            e_rid[i]   = '0;
            e_rdata[i] = '0;
        end

        for (int k = 0; k < NP; k++) begin
            p = (m_rr + k) % NP;
            if (port_req_valid[p] && !m_pend[p] && free_q.size() > 0) begin
                u          = free_q.pop_front();
                e_ready[p] = 1'b1;
                e_start[u] = 1'b1;
                e_ureq[u]  = port_req_data[p];
                last       = p;
            end
        end
        for (int i = 0; i < NU; i++) begin
            if (m_owner[i] >= 0 && m_held[i]) begin
                e_rv[m_owner[i]]    = 1'b1;
                e_rid[m_owner[i]]   = m_tag[i];
                e_rdata[m_owner[i]] = m_res[i];
            end
        end

        check("req_ready", 128'(port_req_ready), 128'(e_ready));
        check("resp_valid", 128'(port_resp_valid), 128'(e_rv));
        check("unit_start", 128'(unit_start), 128'(e_start));
        check("pool_busy", 128'(pool_busy), 128'(n_free == 0));
        check("err_spurious", 128'(err_spurious), 128'(m_err));
        for (int i = 0; i < NP; i++) begin
            check($sformatf("resp_id[%0d]", i), 128'(port_resp_id[i]), 128'(e_rid[i]));
            check($sformatf("resp_data[%0d]", i), 128'(port_resp_data[i]), 128'(e_rdata[i]));
        end
        for (int i = 0; i < NU; i++)
            check($sformatf("unit_req_data[%0d]", i), 128'(unit_req_data[i]), 128'(e_ureq[i]));

        // Apply this cycle's events, each decided from the pre-edge state.
        for (int i = 0; i < NP; i++) hs[i] = e_rv[i] && port_resp_ready[i];
        for (int i = 0; i < NU; i++) begin
            if (m_owner[i] >= 0 && m_held[i] && hs[m_owner[i]]) begin
                m_pend[m_owner[i]] = 1'b0;
                m_owner[i]         = -1;
                m_held[i]          = 1'b0;
            end
        end
        for (int i = 0; i < NU; i++) begin
            if (unit_done[i]) begin
                if (m_owner[i] >= 0 && !m_held[i]) begin
                    m_held[i] = 1'b1;
                    m_res[i]  = unit_resp_data[i];
                end else begin
                    m_err = 1'b1;
                end
            end
        end
        // Replay the grant scan against the pre-edge free set to record ownership.
        free_q.delete();
        for (int i = 0; i < NU; i++) if (e_start[i]) free_q.push_back(i);
        for (int k = 0; k < NP; k++) begin
            p = (m_rr + k) % NP;
            if (e_ready[p]) begin
                u          = free_q.pop_front();
                m_owner[u] = p;
                m_held[u]  = 1'b0;
                m_tag[u]   = port_req_id[p];
                m_pend[p]  = 1'b1;
                if (auto_units) lat[u] = int'($urandom_range(1, 6));
            end
        end
        if (last >= 0) m_rr = (last + 1) % NP;
    endtask

    task automatic advance();
        @(posedge clk);
        @(negedge clk);
        unit_done = '0;
        if (auto_units) begin
            for (int i = 0; i < NU; i++) begin
                if (lat[i] > 0) begin
                    lat[i]--;
                    if (lat[i] == 0) begin
                        unit_done[i]      = 1'b1;
                        unit_resp_data[i] = {$urandom, $urandom};
                    end
                end
            end
        end
    endtask

    task automatic tick();
        settle();
        advance();
    endtask

    task automatic do_reset();
        rst             = 1'b1;
        port_req_valid  = '0;
        unit_done       = '0;
        port_resp_ready = '1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        m_reset();
    endtask

    initial begin
        for (int p = 0; p < NP; p++) begin
            port_req_id[p]   = {8'(p), 8'(p)};
            port_req_data[p] = 72'h100 + 72'(p);
        end
        for (int u = 0; u < NU; u++) unit_resp_data[u] = '0;
        @(negedge clk);
        do_reset();

        // Single request, done five cycles later, response one cycle after done.
        port_req_valid[0] = 1'b1;
        port_req_id[0]    = 16'h0011;
        port_req_data[0]  = 72'h5A;
        settle();
        check("s1_ready0", 128'(port_req_ready[0]), 128'(1));
        check("s1_start0", 128'(unit_start[0]), 128'(1));
        check("s1_udata0", 128'(unit_req_data[0]), 128'h5A);
        advance();
        port_req_valid[0] = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        unit_done[0]      = 1'b1;
        unit_resp_data[0] = 64'hDEAD;
        settle();
        check("s1_rv_done_cycle", 128'(port_resp_valid[0]), 128'(0));
        advance();
        settle();
        check("s1_rv", 128'(port_resp_valid[0]), 128'(1));
        check("s1_rid", 128'(port_resp_id[0]), 128'h0011);
        check("s1_rdata", 128'(port_resp_data[0]), 128'hDEAD);
        advance();

        // All four ports request with the pointer at 0.
        do_reset();
        port_req_id[0]   = 16'h0000;
        port_req_data[0] = 72'h100;
        port_req_valid   = 4'hF;
        settle();
        check("s2_ready_first", 128'(port_req_ready), 128'(4'b0011));
        check("s2_udata1", 128'(unit_req_data[1]), 128'h101);
        advance();
        port_req_valid = 4'b1100;
        tick();
        tick();
        unit_done = 2'b11;
        tick();
        tick();
        port_req_valid = 4'hF;
        settle();
        check("s2_ready_second", 128'(port_req_ready), 128'(4'b1100));
        check("s2_udata0", 128'(unit_req_data[0]), 128'h102);
        advance();
        port_req_valid = 4'b0011;

        // Owner port 2 stalls its response; the held unit must stay unavailable.
        port_resp_ready[2] = 1'b0;
        unit_done[0]       = 1'b1;
        unit_resp_data[0]  = 64'hC0FFEE;
        tick();
        for (int i = 0; i < 4; i++) begin
            settle();
            check("s3_rv2", 128'(port_resp_valid[2]), 128'(1));
            check("s3_rid2", 128'(port_resp_id[2]), 128'h0202);
            check("s3_rdata2", 128'(port_resp_data[2]), 128'hC0FFEE);
            check("s3_busy", 128'(pool_busy), 128'(1));
            check("s3_no_start", 128'(unit_start), 128'(0));
            advance();
        end
        port_resp_ready[2] = 1'b1;
        settle();
        check("s3_no_regrant_same_cycle", 128'(unit_start), 128'(0));
        advance();
        settle();
        check("s3_regrant_start", 128'(unit_start), 128'(2'b01));
        check("s3_regrant_port0", 128'(port_req_ready), 128'(4'b0001));
        advance();
        port_req_valid = '0;

        // A pending port keeps valid high: not ready until after its response handshake.
        do_reset();
        port_req_valid[1] = 1'b1;
        settle();
        check("s4_first_grant", 128'(port_req_ready[1]), 128'(1));
        advance();
        for (int i = 0; i < 3; i++) begin
            settle();
            check("s4_pending_ready", 128'(port_req_ready[1]), 128'(0));
            advance();
        end
        unit_done[0] = 1'b1;
        tick();
        settle();
        check("s4_hs_cycle_ready", 128'(port_req_ready[1]), 128'(0));
        advance();
        settle();
        check("s4_after_hs_ready", 128'(port_req_ready[1]), 128'(1));
        advance();
        port_req_valid[1] = 1'b0;

        // Done on a free unit sets the sticky error and produces no response.
        unit_done[1] = 1'b1;
        settle();
        check("s5_err_same_cycle", 128'(err_spurious), 128'(0));
        advance();
        for (int i = 0; i < 3; i++) begin
            settle();
            check("s5_err_sticky", 128'(err_spurious), 128'(1));
            check("s5_no_resp", 128'(port_resp_valid), 128'(0));
            advance();
        end

        // Reset with both units busy, one of them holding a result.
        do_reset();
        port_req_valid = 4'b0011;
        tick();
        port_req_valid     = '0;
        port_resp_ready[0] = 1'b0;
        tick();
        unit_done[0] = 1'b1;
        tick();
        settle();
        check("s6_hold_before_rst", 128'(port_resp_valid[0]), 128'(1));
        advance();
        do_reset();
        settle();
        check("s6_rv_zero", 128'(port_resp_valid), 128'(0));
        check("s6_rdata_zero", 128'(port_resp_data[0]), 128'(0));
        check("s6_rid_zero", 128'(port_resp_id[0]), 128'(0));
        check("s6_busy_zero", 128'(pool_busy), 128'(0));
        check("s6_err_zero", 128'(err_spurious), 128'(0));
        advance();
        unit_done[1] = 1'b1;
        tick();
        settle();
        check("s6_late_done_err", 128'(err_spurious), 128'(1));
        advance();
        port_req_valid = 4'b1100;
        settle();
        check("s6_all_free_ready", 128'(port_req_ready), 128'(4'b1100));
        check("s6_all_free_start", 128'(unit_start), 128'(2'b11));
        advance();

        // Randomized traffic with emulated units of random latency.
        do_reset();
        auto_units = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            for (int p = 0; p < NP; p++) begin
                port_req_valid[p]  = ($urandom_range(0, 1) == 1);
                port_resp_ready[p] = ($urandom_range(0, 3) != 0);
                port_req_id[p]     = 16'($urandom);
                port_req_data[p]   = {8'($urandom), $urandom, $urandom};
            end
            if (c > 2500 && $urandom_range(0, 99) == 0) begin
                for (int u = 0; u < NU; u++) if (lat[u] == 0) unit_done[u] = 1'b1;
            end
            tick();
        end
        auto_units = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
